// File: rtl/c1541_pkg.sv
// Shared types and constants for the 1541 direct-GCR head emulation.
// A zone selects the bit period; zone 3 is the fastest, outermost density.
package c1541_pkg;

    typedef logic [1:0] zone_t;

    localparam int SYNC_BITS     = 10;
    localparam int GCR_BYTE_BITS = 8;

    // Bit period in ce ticks: (16 - zone) * 4, i.e. 64/60/56/52.
    function automatic logic [6:0] bit_period(input zone_t zone);
        return 7'd64 - {3'd0, zone, 2'b00};
    endfunction

endpackage

// File: rtl/c1541_bitclk.sv
// Zone bit-rate divider: emits one bit strobe per bit period of ce ticks.
// The zone is sampled only at the wrap, so a bit in flight keeps its length.
module c1541_bitclk
    import c1541_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  ce,
    input  logic  run,
    input  zone_t freq,
    output logic  bit_stb
);

    logic [6:0] div;
    zone_t      zone_q;
    logic       wrap;

    assign wrap    = (div == bit_period(zone_q) - 7'd1);
    assign bit_stb = ce & run & wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            div    <= '0;
            zone_q <= freq;
        end else if (ce && run) begin
            if (wrap) begin
                div    <= '0;
                zone_q <= freq;
            end else begin
                div <= div + 7'd1;
            end
        end
    end

endmodule

// File: rtl/c1541_gcr_bitstream.sv
// 1541 head emulation: serialises the GCR track buffer, detects SYNC,
// frames bytes for the drive logic and writes bytes back in write mode.
module c1541_gcr_bitstream
    import c1541_pkg::*;
#(
    parameter int TRK_AW   = 13,
    parameter int BRDY_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              mtr,
    input  logic              mode,
    input  logic [1:0]        freq,
    input  logic              busy,
    input  logic [TRK_AW:0]   track_len,
    output logic [TRK_AW-1:0] buf_addr,
    input  logic [7:0]        buf_rdata,
    output logic [7:0]        buf_wdata,
    output logic              buf_we,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              sync_n,
    output logic              byte_n
);

    localparam int BW = $clog2(BRDY_LEN + 1);

    logic                 run;
    logic                 bit_stb;
    logic [7:0]           cur_byte;
    logic [SYNC_BITS-1:0] hist;
    logic [SYNC_BITS-1:0] hist_next;
    logic [2:0]           bit_idx;
    logic [2:0]           byte_cnt;
    logic                 mode_q;
    logic                 inc_pend;
    logic                 we_q;
    logic [BW-1:0]        brdy_cnt;
    logic                 in_sync_next;
    logic                 boundary;
    logic [TRK_AW:0]      addr_inc;

    assign run = mtr & ~busy & (track_len != '0);

    c1541_bitclk u_bitclk (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .run     (run),
        .freq    (freq),
        .bit_stb (bit_stb)
    );

    // The byte framing counter stalls while the head sits inside a SYNC mark.
    assign hist_next    = {hist[SYNC_BITS-2:0], cur_byte[3'd7 - bit_idx]};
    assign in_sync_next = mode_q & (&hist_next);
    assign boundary     = bit_stb & ~in_sync_next
                        & (byte_cnt == 3'(GCR_BYTE_BITS - 1));
    assign addr_inc     = {1'b0, buf_addr} + (TRK_AW + 1)'(1);

    assign sync_n = ~(run & mode_q & (&hist));
    assign byte_n = ~(run & (brdy_cnt != '0));
    assign buf_we = we_q & run;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_byte  <= '0;
            hist      <= '0;
            bit_idx   <= '0;
            byte_cnt  <= '0;
            mode_q    <= mode;
            inc_pend  <= 1'b0;
            we_q      <= 1'b0;
            brdy_cnt  <= '0;
            dout      <= '0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else begin
            we_q <= 1'b0;
            // Address is stable for a whole bit before bit 7 is needed.
            if (bit_idx == 3'd0 && !bit_stb)
                cur_byte <= buf_rdata;
            if (!run) begin
                brdy_cnt <= '0;
            end else begin
                if (ce && brdy_cnt != '0)
                    brdy_cnt <= brdy_cnt - BW'(1);
                if (inc_pend) begin
                    inc_pend <= 1'b0;
                    buf_addr <= (addr_inc >= track_len) ? '0 : addr_inc[TRK_AW-1:0];
                end
                if (bit_stb) begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        inc_pend <= 1'b1;
                    if (mode_q)
                        hist <= hist_next;
                    byte_cnt <= in_sync_next ? 3'd0 : byte_cnt + 3'd1;
                    if (boundary) begin
                        brdy_cnt <= BW'(BRDY_LEN);
                        mode_q   <= mode;
                        if (mode_q) begin
                            dout <= hist_next[7:0];
                        end else begin
                            buf_wdata <= din;
                            we_q      <= 1'b1;
                        end
                        if (mode_q && !mode)
                            hist <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_c1541_gcr_bitstream.sv
// Self-checking bench for c1541_gcr_bitstream: directed scenarios plus
// randomised tracks compared against a bit-stream reference model.
module tb_c1541_gcr_bitstream;

    localparam int TRK_AW = 13;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ce = 1'b1;
    logic              mtr = 1'b1;
    logic              mode = 1'b1;
    logic [1:0]        freq = 2'd3;
    logic              busy = 1'b0;
    logic [TRK_AW:0]   track_len = 2;
    logic [TRK_AW-1:0] buf_addr;
    logic [7:0]        buf_rdata = 8'h00;
    logic [7:0]        buf_wdata;
    logic              buf_we;
    logic [7:0]        din = 8'h00;
    logic [7:0]        dout;
    logic              sync_n;
    logic              byte_n;

    c1541_gcr_bitstream #(.TRK_AW(TRK_AW), .BRDY_LEN(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .mtr       (mtr),
        .mode      (mode),
        .freq      (freq),
        .busy      (busy),
        .track_len (track_len),
        .buf_addr  (buf_addr),
        .buf_rdata (buf_rdata),
        .buf_wdata (buf_wdata),
        .buf_we    (buf_we),
        .din       (din),
        .dout      (dout),
        .sync_n    (sync_n),
        .byte_n    (byte_n)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:(1<<TRK_AW)-1];
    int unsigned ce_ticks = 0;
    int unsigned base = 0;
    bit          ce_rand = 1'b0;
    bit          mon_on = 1'b0;
    bit          wmon_on = 1'b0;
    int          mon_bad = 0;
    int          wmon_bad = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_dout [$];
    int          exp_pos [$];

    always @(posedge clk) begin
        buf_rdata <= mem[buf_addr];
        if (buf_we) mem[buf_addr] <= buf_wdata;
    end

    always @(posedge clk) if (ce) ce_ticks <= ce_ticks + 1;

    always @(negedge clk) ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;

    always @(negedge clk) begin
        if (mon_on && (byte_n !== 1'b1 || buf_we !== 1'b0 || sync_n !== 1'b1)) mon_bad++;
        if (wmon_on && sync_n !== 1'b1) wmon_bad++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic noteTimeout(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s: observed=timeout expected=event", tag);
    endtask

    task automatic applyStimulus(input logic m, input logic [1:0] f, input int len, input bit ce_r);
        mode      = m;
        freq      = f;
        track_len = len[TRK_AW:0];
        ce_rand   = ce_r;
        busy      = 1'b0;
        mtr       = 1'b1;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base  = ce_ticks;
    endtask

    task automatic waitFall(input string tag, output int unsigned stamp, output bit ok);
        int   n = 0;
        logic prev = byte_n;
        ok = 1'b0;
        stamp = 0;
        while (n < 6000) begin
            @(negedge clk);
            n++;
            if (prev === 1'b1 && byte_n === 1'b0) begin
                ok = 1'b1;
                stamp = ce_ticks;
                break;
            end
            prev = byte_n;
        end
        if (!ok) noteTimeout(tag);
    endtask

    task automatic waitSync(input string tag, input logic level, output int unsigned stamp, output bit ok);
        ok = 1'b0;
        stamp = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (sync_n === level) begin
                ok = 1'b1;
                stamp = ce_ticks;
                break;
            end
        end
        if (!ok) noteTimeout(tag);
    endtask

    task automatic waitWe(input string tag, output int unsigned stamp, output bit ok);
        ok = 1'b0;
        stamp = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (buf_we === 1'b1) begin
                ok = 1'b1;
                stamp = ce_ticks;
                break;
            end
        end
        if (!ok) noteTimeout(tag);
    endtask

    // Bit-stream reference: a run of ten ones is SYNC, framing restarts after it.
    task automatic buildModel(input int len, input int nbytes);
        int         k = 0;
        int         ones = 0;
        int         cnt = 0;
        logic [7:0] acc = 8'h00;
        logic [7:0] b;
        logic       bt;
        exp_dout.delete();
        exp_pos.delete();
        while (exp_dout.size() < nbytes && k < 200000) begin
            b  = mem[(k / 8) % len];
            bt = b[7 - (k % 8)];
            k++;
            ones = bt ? ones + 1 : 0;
            acc  = {acc[6:0], bt};
            if (ones >= 10) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 8) begin
                    exp_dout.push_back(acc);
                    exp_pos.push_back(k);
                    cnt = 0;
                end
            end
        end
    endtask

    task automatic checkStream(input string tag, input int len, input int period, input int nbytes);
        int unsigned stamp;
        int unsigned prev = base;
        int          prevpos = 0;
        bit          ok;
        buildModel(len, nbytes);
        for (int j = 0; j < exp_dout.size(); j++) begin
            waitFall($sformatf("%s_wait%0d", tag, j), stamp, ok);
            if (!ok) return;
            checkOutput($sformatf("%s_dout%0d", tag, j), {24'd0, dout}, {24'd0, exp_dout[j]});
            checkOutput($sformatf("%s_gap%0d", tag, j), stamp - prev, (exp_pos[j] - prevpos) * period);
            prev    = stamp;
            prevpos = exp_pos[j];
        end
    endtask

    initial begin
        int unsigned t0, t1, t2;
        bit          ok;
        int          n;
        int          len;
        logic [1:0]  f;
        logic [7:0]  exp_w;
        bit          has_zero;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_addr", {19'd0, buf_addr}, 32'd0);
        checkOutput("rst_dout", {24'd0, dout}, 32'd0);
        checkOutput("rst_sync_n", {31'd0, sync_n}, 32'd1);
        checkOutput("rst_byte_n", {31'd0, byte_n}, 32'd1);
        checkOutput("rst_we", {31'd0, buf_we}, 32'd0);
        checkOutput("rst_wdata", {24'd0, buf_wdata}, 32'd0);

        // Basic read at the fastest zone, then byte-ready pulse width
        $display("[TB] basic read");
        mem[0] = 8'h55;
        mem[1] = 8'hAA;
        applyStimulus(1'b1, 2'd3, 2, 1'b0);
        checkStream("basic", 2, 52, 3);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (byte_n === 1'b0) n++;
            else break;
        end
        checkOutput("brdy_width", n, 32'd16);

        // SYNC detection and realignment
        $display("[TB] sync");
        mem[0] = 8'hFF;
        mem[1] = 8'hFF;
        mem[2] = 8'h52;
        applyStimulus(1'b1, 2'd3, 3, 1'b0);
        waitFall("sync_first", t0, ok);
        checkOutput("sync_first_dout", {24'd0, dout}, 32'hFF);
        waitSync("sync_fall", 1'b0, t1, ok);
        checkOutput("sync_fall_time", t1 - t0, 32'd104);
        waitSync("sync_rise", 1'b1, t1, ok);
        checkOutput("sync_rise_time", t1 - t0, 32'd468);
        waitFall("sync_byte", t1, ok);
        checkOutput("sync_byte_dout", {24'd0, dout}, 32'h52);
        checkOutput("sync_byte_time", t1 - t0, 32'd832);

        // Circular addressing over a three-byte track
        $display("[TB] address wrap");
        for (int i = 0; i < 3; i++) mem[i] = 8'($urandom) & 8'h7F;
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), 3, 1'b1);
        for (int j = 0; j < 7; j++) begin
            waitFall($sformatf("wrap_wait%0d", j), t0, ok);
            checkOutput($sformatf("wrap_addr%0d", j), {19'd0, buf_addr}, j % 3);
            checkOutput($sformatf("wrap_dout%0d", j), {24'd0, dout}, {24'd0, mem[j % 3]});
        end
        ce_rand = 1'b0;

        // Zone change in mid-bit keeps the current bit's length
        $display("[TB] freq change");
        mem[0] = 8'h55;
        mem[1] = 8'hAA;
        applyStimulus(1'b1, 2'd0, 2, 1'b0);
        waitFall("freq_a", t0, ok);
        repeat (20) @(negedge clk);
        freq = 2'd3;
        waitFall("freq_b", t1, ok);
        checkOutput("freq_gap1", t1 - t0, 32'd428);
        waitFall("freq_c", t2, ok);
        checkOutput("freq_gap2", t2 - t1, 32'd416);

        // Write mode commits din at every byte boundary
        $display("[TB] write");
        din = 8'h4B;
        applyStimulus(1'b0, 2'd0, 4, 1'b0);
        wmon_on = 1'b1;
        t0 = base;
        for (int j = 0; j < 5; j++) begin
            exp_w = din;
            waitWe($sformatf("wr_wait%0d", j), t1, ok);
            checkOutput($sformatf("wr_data%0d", j), {24'd0, buf_wdata}, {24'd0, exp_w});
            checkOutput($sformatf("wr_addr%0d", j), {19'd0, buf_addr}, j % 4);
            checkOutput($sformatf("wr_gap%0d", j), t1 - t0, 32'd512);
            @(negedge clk);
            checkOutput($sformatf("wr_pulse%0d", j), {31'd0, buf_we}, 32'd0);
            checkOutput($sformatf("wr_next%0d", j), {19'd0, buf_addr}, (j + 1) % 4);
            t0 = t1;
            din = 8'($urandom);
        end
        wmon_on = 1'b0;
        checkOutput("wr_sync_high", wmon_bad, 32'd0);

        // Busy freezes the head; busy during byte-ready truncates it
        $display("[TB] busy and reset");
        mem[0] = 8'h55;
        mem[1] = 8'hAA;
        applyStimulus(1'b1, 2'd3, 2, 1'b0);
        waitFall("busy_a", t0, ok);
        repeat (100) @(negedge clk);
        busy   = 1'b1;
        mon_on = 1'b1;
        repeat (1000) @(negedge clk);
        mon_on = 1'b0;
        busy   = 1'b0;
        waitFall("busy_b", t1, ok);
        checkOutput("busy_gap", t1 - t0, 32'd1416);
        checkOutput("busy_dout", {24'd0, dout}, 32'hAA);
        checkOutput("busy_frozen", mon_bad, 32'd0);
        repeat (3) @(negedge clk);
        busy = 1'b1;
        #1;
        checkOutput("busy_trunc", {31'd0, byte_n}, 32'd1);
        @(negedge clk);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("busy_abort", {31'd0, byte_n}, 32'd1);

        // Reset in the middle of a byte-ready pulse
        waitFall("rst_mid", t0, ok);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstmid_byte_n", {31'd0, byte_n}, 32'd1);
        checkOutput("rstmid_addr", {19'd0, buf_addr}, 32'd0);
        checkOutput("rstmid_dout", {24'd0, dout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomised tracks, zones and ce patterns
        for (int it = 0; it < 3; it++) begin
            $display("[TB] random track %0d", it);
            len = $urandom_range(2, 6);
            has_zero = 1'b0;
            for (int i = 0; i < len; i++) begin
                mem[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                if (mem[i] != 8'hFF) has_zero = 1'b1;
            end
            if (!has_zero) mem[0] = 8'h52;
            f = 2'($urandom_range(0, 3));
            applyStimulus(1'b1, f, len, 1'b1);
            checkStream($sformatf("rand%0d", it), len, 64 - 4 * int'(f), 6);
        end
        ce_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
